// File: rtl/regfile_pkg.sv
// Shared register-file constants and controller state encoding.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: clears the dual-port RAM after reset, then serves 1 write or 2 reads per cycle.
// Latency: read data valid 1 cycle after acceptance; writes land at the accepting edge.
// Backpressure: nothing accepted during clear; a write stalls a same-cycle read (rd_ready low).
module regfile_port_ctrl #(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int AW   = regfile_pkg::AW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rd_req,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rd_ready,
  output logic            rd_valid,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            wr_ready,
  output logic            init_done,
  output logic [AW-1:0]   ram_ada,
  output logic [XLEN-1:0] ram_dina,
  output logic            ram_wrea,
  output logic            ram_cea,
  output logic            ram_ocea,
  output logic            ram_reseta,
  input  logic [XLEN-1:0] ram_douta,
  output logic [AW-1:0]   ram_adb,
  output logic [XLEN-1:0] ram_dinb,
  output logic            ram_wreb,
  output logic            ram_ceb,
  output logic            ram_oceb,
  output logic            ram_resetb,
  input  logic [XLEN-1:0] ram_doutb
);
  import regfile_pkg::state_t;
  import regfile_pkg::CLEAR;
  import regfile_pkg::RUN;

  state_t          state;
  logic [3:0]      cnt;
  logic            clr_vld;
  logic            init_q;
  logic            rd_vld_q;
  logic            rs1_zero_q;
  logic            rs2_zero_q;
  logic [AW-1:0]   ada_q;
  logic [AW-1:0]   adb_q;
  logic [XLEN-1:0] rs1_hold;
  logic [XLEN-1:0] rs2_hold;

  logic run;
  logic wr_mem;
  logic rd_acc;

  assign run    = (state == RUN);
  assign wr_mem = run && wr_en && (wr_addr != '0);
  assign rd_acc = run && rd_req && !wr_en;

  assign rd_ready   = run && !wr_en;
  assign wr_ready   = run;
  assign init_done  = init_q;
  assign rd_valid   = rd_vld_q;
  assign ram_ocea   = 1'b1;
  assign ram_oceb   = 1'b1;
  assign ram_reseta = 1'b0;
  assign ram_resetb = 1'b0;

  // Port A clears the lower 16 entries while port B clears the upper 16.
  always_comb begin
    ram_ada  = ada_q;
    ram_adb  = adb_q;
    ram_dina = '0;
    ram_dinb = '0;
    ram_cea  = 1'b0;
    ram_ceb  = 1'b0;
    ram_wrea = 1'b0;
    ram_wreb = 1'b0;
    if (!run) begin
      if (clr_vld) begin
        ram_ada  = AW'({1'b0, cnt});
        ram_adb  = AW'({1'b1, cnt});
        ram_cea  = 1'b1;
        ram_ceb  = 1'b1;
        ram_wrea = 1'b1;
        ram_wreb = 1'b1;
      end
    end else if (wr_mem) begin
      ram_ada  = wr_addr;
      ram_dina = wr_data;
      ram_cea  = 1'b1;
      ram_wrea = 1'b1;
    end else if (rd_acc) begin
      ram_ada = rs1_addr;
      ram_adb = rs2_addr;
      ram_cea = 1'b1;
      ram_ceb = 1'b1;
    end
  end

  // clr_vld spends one cycle arming so the first RUN cycle follows the 17th edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      cnt     <= 4'd0;
      clr_vld <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (!clr_vld) begin
            clr_vld <= 1'b1;
          end else if (cnt == 4'd15) begin
            state   <= RUN;
            clr_vld <= 1'b0;
            init_q  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RUN: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign rs1_data = rd_vld_q ? (rs1_zero_q ? '0 : ram_douta) : rs1_hold;
  assign rs2_data = rd_vld_q ? (rs2_zero_q ? '0 : ram_doutb) : rs2_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q   <= 1'b0;
      rs1_zero_q <= 1'b0;
      rs2_zero_q <= 1'b0;
      rs1_hold   <= '0;
      rs2_hold   <= '0;
      ada_q      <= '0;
      adb_q      <= '0;
    end else begin
      rd_vld_q <= rd_acc;
      ada_q    <= ram_ada;
      adb_q    <= ram_adb;
      if (rd_acc) begin
        rs1_zero_q <= (rs1_addr == '0);
        rs2_zero_q <= (rs2_addr == '0);
      end
      if (rd_vld_q) begin
        rs1_hold <= rs1_data;
        rs2_hold <= rs2_data;
      end
    end
  end
endmodule
